fifo_ns_ctrl: RTL and testbench
===============================

// Module: fifo_ns_ctrl
// PURPOSE
//  Registered FIFO operation state machine. Samples wr_en/rd_en each clock and decides
//  the FIFO state (IDLE/WRITE/READ/WR_ERROR/RD_ERROR) against the current fill level.
//  Sits directly upstream of the address/count calculation stage, which consumes state.
//  Also decodes status flags (full/empty) and one-cycle handshake strobes (ack/err).
// PARAMETERS
//  DEPTH    8  number of FIFO entries; must be < 2**CNT_W
//  CNT_W    4  width of data_count
//  STATE_W  3  width of state encoding (fixed at 3)
// PORTS
//  clk         in   1        rising-edge clock
//  reset_n     in   1        asynchronous active-low reset
//  wr_en       in   1        write request, sampled at rising edge of clk
//  rd_en       in   1        read request, sampled at rising edge of clk
//  data_count  in   CNT_W    registered entry count; updated by the calculation stage one edge after state
//  state       out  STATE_W  registered state: IDLE=000 WRITE=001 READ=010 WR_ERROR=011 RD_ERROR=100
//  full        out  1        effective count == DEPTH
//  empty       out  1        effective count == 0
//  wr_ack      out  1        high while state==WRITE
//  wr_err      out  1        high while state==WR_ERROR
//  rd_ack      out  1        high while state==READ
//  rd_err      out  1        high while state==RD_ERROR
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE immediately; wr_ack/wr_err/rd_ack/rd_err=0; full=0, empty=1
//    (external count register also resets to 0). Reset mid-operation aborts the in-flight state
//    with no further ack/err; first decision after release occurs at the first rising edge.
//  - Lookahead: data_count lags state by one edge. eff_count (CNT_W bits) =
//    data_count+1 if state==WRITE; data_count-1 if state==READ; else data_count.
//  - Next-state (registered at every rising edge, from wr_en, rd_en, eff_count):
//      wr_en=1 rd_en=0 : eff_count==DEPTH -> WR_ERROR, else WRITE
//      wr_en=0 rd_en=1 : eff_count==0     -> RD_ERROR, else READ
//      wr_en=1 rd_en=1 : IDLE (simultaneous request rejected, no ack, no err)
//      wr_en=0 rd_en=0 : IDLE
//    Any state may go to any state; no state is held without a new request. Unused encodings
//    101..111 -> IDLE at next edge, all strobes 0 while present.
//  - Latency: request sampled at edge k -> state/strobe valid from edge k to edge k+1 (one cycle).
//    Back-to-back requests give one WRITE/READ per cycle with no bubble.
//  - full/empty: combinational decode of eff_count (registered sources only, glitch-free at edges).
//    full and empty never both 1 (DEPTH>0).
//  - Error states never modify count: calculation stage holds head/tail/count in WR_ERROR/RD_ERROR.
//  - Arithmetic: eff_count never wraps because WRITE is only entered below DEPTH, READ only above 0.
// CONFIGURATION
//  FIFO_ERR_CNT_EN defined: adds outputs wr_err_cnt[7:0], rd_err_cnt[7:0]; each increments by 1
//    at the edge that registers WR_ERROR / RD_ERROR respectively; saturates at 8'hFF (no wrap);
//    async reset to 0 with reset_n.
//  FIFO_ERR_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Hold reset_n=0, toggle wr_en -> state=000, empty=1, full=0, all strobes 0; release -> IDLE.
//  2. From empty, wr_en=1 for 9 edges -> WRITE x8 (wr_ack=1 each cycle), full=1 after 8th, 9th -> WR_ERROR, wr_err=1.
//  3. From empty, rd_en=1 one edge -> RD_ERROR, rd_err=1, empty stays 1; then 1 write, 2 reads -> WRITE, READ, RD_ERROR.
//  4. Count=3, wr_en=rd_en=1 -> IDLE, no strobes, count stays 3; then alternating write/read -> WRITE, READ, WRITE.
//  5. reset_n pulsed low mid back-to-back writes at count=5 -> state=IDLE and wr_ack=0 without a clock edge.
//  6. FIFO_ERR_CNT_EN: 300 reads on empty -> rd_err_cnt=8'hFF (saturated), wr_err_cnt=0.

Source files
------------

// File: rtl/fifo_ns_ctrl.sv
// FIFO operation state machine: registers IDLE/WRITE/READ/WR_ERROR/RD_ERROR from wr_en/rd_en
// against a lookahead fill level. Define FIFO_ERR_CNT_EN to add saturating error counters.
module fifo_ns_ctrl #(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 4,
  parameter int STATE_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [CNT_W-1:0]   data_count,
  output logic [STATE_W-1:0] state,
  output logic               full,
  output logic               empty,
  output logic               wr_ack,
  output logic               wr_err,
  output logic               rd_ack,
`ifdef FIFO_ERR_CNT_EN
  output logic               rd_err,
  output logic [7:0]         wr_err_cnt,
  output logic [7:0]         rd_err_cnt
`else
  output logic               rd_err
`endif
);

  // state | meaning
  // IDLE     | no request, or simultaneous write+read rejected
  // WRITE    | write accepted this cycle
  // READ     | read accepted this cycle
  // WR_ERROR | write requested while full
  // RD_ERROR | read requested while empty
  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_WRITE    = 3'b001,
    S_READ     = 3'b010,
    S_WR_ERROR = 3'b011,
    S_RD_ERROR = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] eff_count;
  logic             state_valid;

  // data_count trails state by one edge, so fold in the operation now in flight.
  always_comb begin
    eff_count = data_count;
    if (state_q == S_WRITE)     eff_count = data_count + ONE_C;
    else if (state_q == S_READ) eff_count = data_count - ONE_C;
  end

  assign state_valid = (state_q == S_IDLE)  || (state_q == S_WRITE) ||
                       (state_q == S_READ)  || (state_q == S_WR_ERROR) ||
                       (state_q == S_RD_ERROR);

  always_comb begin
    state_d = S_IDLE;
    if (state_valid) begin
      if (wr_en && !rd_en) begin
        state_d = (eff_count == DEPTH_C) ? S_WR_ERROR : S_WRITE;
      end else if (!wr_en && rd_en) begin
        state_d = (eff_count == '0) ? S_RD_ERROR : S_READ;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  assign state  = STATE_W'(state_q);
  assign full   = (eff_count == DEPTH_C);
  assign empty  = (eff_count == '0);
  assign wr_ack = (state_q == S_WRITE);
  assign wr_err = (state_q == S_WR_ERROR);
  assign rd_ack = (state_q == S_READ);
  assign rd_err = (state_q == S_RD_ERROR);

`ifdef FIFO_ERR_CNT_EN
  logic [7:0] wr_err_cnt_q, wr_err_cnt_d;
  logic [7:0] rd_err_cnt_q, rd_err_cnt_d;

  // Counters step on the edge that registers the error state and stick at 8'hFF.
  always_comb begin
    wr_err_cnt_d = wr_err_cnt_q;
    rd_err_cnt_d = rd_err_cnt_q;
    if (state_d == S_WR_ERROR && wr_err_cnt_q != 8'hFF) wr_err_cnt_d = wr_err_cnt_q + 8'd1;
    if (state_d == S_RD_ERROR && rd_err_cnt_q != 8'hFF) rd_err_cnt_d = rd_err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_err_cnt_q <= '0;
      rd_err_cnt_q <= '0;
    end else begin
      wr_err_cnt_q <= wr_err_cnt_d;
      rd_err_cnt_q <= rd_err_cnt_d;
    end
  end

  assign wr_err_cnt = wr_err_cnt_q;
  assign rd_err_cnt = rd_err_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_ns_ctrl.sv
// Self-checking bench for fifo_ns_ctrl: vector table, corner sequences and random traffic
// against an occupancy-based reference model. Follows FIFO_ERR_CNT_EN when defined.
module tb_fifo_ns_ctrl;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  localparam int ST_IDLE = 0, ST_WRITE = 1, ST_READ = 2, ST_WERR = 3, ST_RERR = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             wr_en, rd_en;
  logic [CNT_W-1:0] data_count;
  logic [2:0]       state;
  logic             full, empty, wr_ack, wr_err, rd_ack, rd_err;
`ifdef FIFO_ERR_CNT_EN
  logic [7:0]       wr_err_cnt, rd_err_cnt;
`endif

  fifo_ns_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .STATE_W(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .data_count (data_count),
    .state      (state),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
`ifdef FIFO_ERR_CNT_EN
    .rd_err     (rd_err),
    .wr_err_cnt (wr_err_cnt),
    .rd_err_cnt (rd_err_cnt)
`else
    .rd_err     (rd_err)
`endif
  );

  always #5 clk = ~clk;

  // Downstream calculation stage: commits the count one edge after the state.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)              data_count <= '0;
    else if (state == 3'b001)  data_count <= data_count + 1'b1;
    else if (state == 3'b010)  data_count <= data_count - 1'b1;
  end

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: occupancy = number of entries the FIFO holds once accepted ops commit.
  int occ, exp_state, exp_wcnt, exp_rcnt;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    occ = 0; exp_state = ST_IDLE; exp_wcnt = 0; exp_rcnt = 0;
  endtask

  task automatic model_apply(input logic w, input logic r);
    exp_state = ST_IDLE;
    if (w && !r) begin
      if (occ == DEPTH) begin
        exp_state = ST_WERR;
        if (exp_wcnt < 255) exp_wcnt++;
      end else begin
        exp_state = ST_WRITE;
        occ++;
      end
    end else if (!w && r) begin
      if (occ == 0) begin
        exp_state = ST_RERR;
        if (exp_rcnt < 255) exp_rcnt++;
      end else begin
        exp_state = ST_READ;
        occ--;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".state"},  int'(state),  exp_state);
    chk({tag, ".full"},   int'(full),   int'(occ == DEPTH));
    chk({tag, ".empty"},  int'(empty),  int'(occ == 0));
    chk({tag, ".wr_ack"}, int'(wr_ack), int'(exp_state == ST_WRITE));
    chk({tag, ".wr_err"}, int'(wr_err), int'(exp_state == ST_WERR));
    chk({tag, ".rd_ack"}, int'(rd_ack), int'(exp_state == ST_READ));
    chk({tag, ".rd_err"}, int'(rd_err), int'(exp_state == ST_RERR));
`ifdef FIFO_ERR_CNT_EN
    chk({tag, ".wr_err_cnt"}, int'(wr_err_cnt), exp_wcnt);
    chk({tag, ".rd_err_cnt"}, int'(rd_err_cnt), exp_rcnt);
`endif
  endtask

  // Called at a negedge: drive request, let the edge register it, check at next negedge.
  task automatic do_step(input logic w, input logic r, input string tag);
    wr_en = w; rd_en = r;
    @(posedge clk);
    model_apply(w, r);
    @(negedge clk);
    check_outputs(tag);
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic [2:0] st;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{wr:1'b0, rd:1'b1, st:3'd4, full:1'b0, empty:1'b1};
    vecs[1]  = '{wr:1'b1, rd:1'b0, st:3'd1, full:1'b0, empty:1'b0};
    vecs[2]  = '{wr:1'b0, rd:1'b1, st:3'd2, full:1'b0, empty:1'b1};
    vecs[3]  = '{wr:1'b0, rd:1'b1, st:3'd4, full:1'b0, empty:1'b1};
    vecs[4]  = '{wr:1'b1, rd:1'b0, st:3'd1, full:1'b0, empty:1'b0};
    vecs[5]  = '{wr:1'b1, rd:1'b0, st:3'd1, full:1'b0, empty:1'b0};
    vecs[6]  = '{wr:1'b1, rd:1'b0, st:3'd1, full:1'b0, empty:1'b0};
    vecs[7]  = '{wr:1'b1, rd:1'b1, st:3'd0, full:1'b0, empty:1'b0};
    vecs[8]  = '{wr:1'b0, rd:1'b0, st:3'd0, full:1'b0, empty:1'b0};
    vecs[9]  = '{wr:1'b1, rd:1'b0, st:3'd1, full:1'b0, empty:1'b0};
    vecs[10] = '{wr:1'b0, rd:1'b1, st:3'd2, full:1'b0, empty:1'b0};
    vecs[11] = '{wr:1'b1, rd:1'b0, st:3'd1, full:1'b0, empty:1'b0};

    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    model_reset();

    // Reset held: requests must be ignored.
    repeat (4) begin
      @(negedge clk);
      wr_en = ~wr_en;
    end
    @(negedge clk);
    check_outputs("reset_hold");
    wr_en = 1'b0;
    reset_n = 1'b1;
    do_step(1'b0, 1'b0, "post_reset");

    for (int i = 0; i < 12; i++) begin
      do_step(vecs[i].wr, vecs[i].rd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_state", i), int'(state), int'(vecs[i].st));
      chk($sformatf("vec%0d.tbl_full", i),  int'(full),  int'(vecs[i].full));
      chk($sformatf("vec%0d.tbl_empty", i), int'(empty), int'(vecs[i].empty));
    end
    chk("count_after_table", int'(data_count) + int'(state == 3'd1), 4);

    // Fill from 4 to 8, then one write too many.
    for (int i = 0; i < 4; i++) do_step(1'b1, 1'b0, "fill");
    chk("full_after_fill", int'(full), 1);
    do_step(1'b1, 1'b0, "overfill");
    chk("overfill_wr_err", int'(wr_err), 1);
    chk("overfill_state", int'(state), ST_WERR);
    do_step(1'b1, 1'b0, "overfill2");

    // Async reset during back-to-back writes at count 5.
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) do_step(1'b1, 1'b0, "b2b_wr");
    chk("b2b_wr_ack_before_reset", int'(wr_ack), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst.state", int'(state), ST_IDLE);
    chk("async_rst.wr_ack", int'(wr_ack), 0);
    chk("async_rst.empty", int'(empty), 1);
    chk("async_rst.full", int'(full), 0);
    model_reset();
    @(negedge clk);
    wr_en = 1'b0;
    reset_n = 1'b1;
    do_step(1'b0, 1'b1, "after_async_rst");

    // Randomised traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 600; i++) begin
      int p;
      logic w, r;
      p = $urandom_range(0, 9);
      if (((i / 100) % 2) == 0) begin
        w = (p < 6); r = (p >= 5);
      end else begin
        w = (p < 3); r = (p >= 2);
      end
      do_step(w, r, "rand");
    end

`ifdef FIFO_ERR_CNT_EN
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 300; i++) do_step(1'b0, 1'b1, "rd_sat");
    chk("rd_err_cnt_sat", int'(rd_err_cnt), 255);
    chk("wr_err_cnt_zero", int'(wr_err_cnt), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
